seg_scan_ctrl: RTL and testbench

Scan controller for a 4-digit multiplexed seven-segment display. It paces a mod-4 digit-select counter from a prescaler. It presents the selected digit's nibble, decimal point and active-low anode enables to the segment decoder. New display values are accepted through a load/ack handshake and committed only at frame boundaries, so a frame never shows digits from two different values.

---
 rtl/seg_scan_pkg.sv | 30 +++
 rtl/seg_scan_ctrl_digit_counter.sv | 24 ++
 rtl/seg_scan_ctrl.sv | 131 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types, constants and helpers for the seven-segment scan controller.
package seg_scan_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned NIB_W      = 4;
  localparam int unsigned VAL_W      = NUM_DIGITS * NIB_W;

  localparam logic [NUM_DIGITS-1:0] AN_OFF   = 4'b1111;
  localparam logic [NUM_DIGITS-1:0] AN_RESET = 4'b1110;

  // Index of a display digit; 0 is the rightmost digit.
  typedef logic [SEL_W-1:0] digit_idx_t;

  localparam digit_idx_t LAST_DIGIT = digit_idx_t'(NUM_DIGITS - 1);

  // Active-low anode pattern that lights only the indexed digit.
  function automatic logic [NUM_DIGITS-1:0] an_onehot_low(input digit_idx_t idx);
    logic [NUM_DIGITS-1:0] onehot;
    onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
    return ~onehot;
  endfunction

  // Extracts the nibble belonging to the indexed digit.
  function automatic logic [NIB_W-1:0] nibble_at(input logic [VAL_W-1:0] v,
                                                 input digit_idx_t       idx);
    return v[idx*NIB_W +: NIB_W];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_digit_counter.sv
// Mod-4 digit-select counter, advanced by the prescaler tick.
module digit_counter
  import seg_scan_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [SEL_W-1:0] q
);

  logic [SEL_W-1:0] r_q;

  // Counter state: synchronous active-low clear, wraps 3 -> 0 by width.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_q <= '0;
    end else if (inc) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed seven-segment display.
// Values are accepted via load/load_ack and only committed at frame
// boundaries so a single frame never mixes digits of two values.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned PRE_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VAL_W-1:0]      value_in,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  output logic                  load_ack,
  output logic                  frame_start,
  output logic [SEL_W-1:0]      digit_sel,
  output logic [NUM_DIGITS-1:0] an,
  output logic [NIB_W-1:0]      digit,
  output logic                  dp
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]      r_pre;
  logic                  w_tick;
  digit_idx_t            w_sel;
  logic                  w_fb;

  logic [VAL_W-1:0]      r_pend_val;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic                  r_pend;
  logic [VAL_W-1:0]      r_shown_val;
  logic [NUM_DIGITS-1:0] r_shown_dp;
  logic                  r_load_ack;
  logic                  r_frame_start;

  logic [NUM_DIGITS-1:0] w_lz;
  logic                  w_zero_run;
  logic                  w_blank;

  assign w_tick = (r_pre == PRE_LAST);
  assign w_fb   = w_tick & (w_sel == LAST_DIGIT);

  // Prescaler: counts 0..PRESCALE-1 and wraps; tick marks the last count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pre <= '0;
    end else if (w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  digit_counter u_digit_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (w_tick),
    .q     (w_sel)
  );

  // Frame-start pulse, high in the first cycle digit 0 is lit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_fb;
    end
  end

  // Load handshake. A load coinciding with the frame boundary wins over
  // any older pending request and is committed straight from the inputs;
  // the pending flag is cleared either way so only one ack is produced.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pend_val  <= '0;
      r_pend_dp   <= '0;
      r_pend      <= 1'b0;
      r_shown_val <= '0;
      r_shown_dp  <= '0;
      r_load_ack  <= 1'b0;
    end else begin
      r_load_ack <= 1'b0;
      if (w_fb && load) begin
        r_shown_val <= value_in;
        r_shown_dp  <= dp_in;
        r_pend      <= 1'b0;
        r_load_ack  <= 1'b1;
      end else if (w_fb && r_pend) begin
        r_shown_val <= r_pend_val;
        r_shown_dp  <= r_pend_dp;
        r_pend      <= 1'b0;
        r_load_ack  <= 1'b1;
      end else if (load) begin
        r_pend_val <= value_in;
        r_pend_dp  <= dp_in;
        r_pend     <= 1'b1;
      end
    end
  end

  // Leading-zero map: digit i is a leading zero when nibbles i..3 are all 0.
  always_comb begin
    w_lz       = '0;
    w_zero_run = 1'b1;
    for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run = w_zero_run & (nibble_at(r_shown_val, digit_idx_t'(i)) == '0);
      w_lz[i]    = w_zero_run;
    end
  end

  // Output decode for the currently selected digit, including blanking.
  always_comb begin
    w_blank = blank_lz & w_lz[w_sel];
    digit   = nibble_at(r_shown_val, w_sel);
    if (w_blank) begin
      an = AN_OFF;
      dp = 1'b1;
    end else begin
      an = an_onehot_low(w_sel);
      dp = ~r_shown_dp[w_sel];
    end
  end

  assign load_ack    = r_load_ack;
  assign frame_start = r_frame_start;
  assign digit_sel   = w_sel;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl with PRESCALE=4.
// "k" is the number of rising edges since reset was last released.
module tb_seg_scan_ctrl;

  localparam int unsigned PS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic        load_ack;
  logic        frame_start;
  logic [1:0]  digit_sel;
  logic [3:0]  an;
  logic [3:0]  digit;
  logic        dp;

  seg_scan_ctrl #(.PRESCALE(PS), .PRE_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .value_in    (value_in),
    .dp_in       (dp_in),
    .load        (load),
    .blank_lz    (blank_lz),
    .load_ack    (load_ack),
    .frame_start (frame_start),
    .digit_sel   (digit_sel),
    .an          (an),
    .digit       (digit),
    .dp          (dp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      nm;
    logic [1:0] sel;
    logic [3:0] an;
    logic [3:0] dig;
    logic       dp;
    logic       ack;
    logic       fs;
    bit         chk_dig;
  } snap_t;

  snap_t snap_q[$];
  int    ack_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    base     = 0;
  bit    done     = 1'b0;
  bit    flushed  = 1'b0;

  function automatic void chk_at(int k, string nm, logic [1:0] s, logic [3:0] a,
                                 logic [3:0] d, logic p, logic ak, logic f, bit cd);
    snap_t t;
    t.cyc = base + k; t.nm = nm; t.sel = s; t.an = a; t.dig = d;
    t.dp = p; t.ack = ak; t.fs = f; t.chk_dig = cd;
    snap_q.push_back(t);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(int k);
    while (cyc < base + k) step();
  endtask

  task automatic pulse_load(logic [15:0] v, logic [3:0] d);
    load = 1'b1; value_in = v; dp_in = d;
    step();
    load = 1'b0;
  endtask

  // Monitor: pops expected snapshots and expected ack cycles.
  always @(negedge clk) begin
    snap_t t;
    int    e;
    while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) begin
      t = snap_q.pop_front();
      n_checks++;
      if (t.cyc != cyc) begin
        n_errors++;
        $display("FAIL %s: sample slot %0d missed (now %0d)", t.nm, t.cyc, cyc);
      end else if (digit_sel !== t.sel || an !== t.an || dp !== t.dp ||
                   load_ack !== t.ack || frame_start !== t.fs ||
                   (t.chk_dig && digit !== t.dig)) begin
        n_errors++;
        $display("FAIL %s: got sel=%0d an=%b digit=%h dp=%b ack=%b fs=%b, expected sel=%0d an=%b digit=%h dp=%b ack=%b fs=%b",
                 t.nm, digit_sel, an, digit, dp, load_ack, frame_start,
                 t.sel, t.an, t.dig, t.dp, t.ack, t.fs);
      end
    end
    if (load_ack === 1'b1) begin
      n_checks++;
      if (ack_q.size() == 0) begin
        n_errors++;
        $display("FAIL ack_unexpected: load_ack=1 at cycle %0d, expected no ack", cyc);
      end else begin
        e = ack_q.pop_front();
        if (e != cyc) begin
          n_errors++;
          $display("FAIL ack_timing: load_ack at cycle %0d, expected at cycle %0d", cyc, e);
        end
      end
    end
    if (done && !flushed) begin
      flushed = 1'b1;
      while (snap_q.size() > 0) begin
        t = snap_q.pop_front();
        n_checks++; n_errors++;
        $display("FAIL %s: never sampled, expected at cycle %0d", t.nm, t.cyc);
      end
      while (ack_q.size() > 0) begin
        e = ack_q.pop_front();
        n_checks++; n_errors++;
        $display("FAIL ack_missing: got no ack, expected at cycle %0d", e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; value_in = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    base  = cyc;

    // idle scan after reset
    chk_at(0,   "reset_state",   2'd0, 4'b1110, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(3,   "hold_digit0",   2'd0, 4'b1110, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(4,   "step_digit1",   2'd1, 4'b1101, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(8,   "step_digit2",   2'd2, 4'b1011, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(12,  "step_digit3",   2'd3, 4'b0111, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(15,  "pre_frame",     2'd3, 4'b0111, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(16,  "frame1_noack",  2'd0, 4'b1110, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk_at(17,  "fs_one_cycle",  2'd0, 4'b1110, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    // 12A4 pending, not yet shown
    chk_at(28,  "pend_hidden",   2'd3, 4'b0111, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(32,  "commit_12A4",   2'd0, 4'b1110, 4'h4, 1'b1, 1'b1, 1'b1, 1'b1);
    chk_at(33,  "ack_one_cyc",   2'd0, 4'b1110, 4'h4, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(36,  "12A4_d1_dp",    2'd1, 4'b1101, 4'hA, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_at(40,  "12A4_d2",       2'd2, 4'b1011, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(44,  "12A4_d3",       2'd3, 4'b0111, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1);
    // 1111 then 2222 in one frame
    chk_at(60,  "old_until_fb",  2'd3, 4'b0111, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(64,  "commit_2222",   2'd0, 4'b1110, 4'h2, 1'b1, 1'b1, 1'b1, 1'b1);
    chk_at(68,  "2222_d1",       2'd1, 4'b1101, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(76,  "2222_d3",       2'd3, 4'b0111, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(80,  "single_ack",    2'd0, 4'b1110, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1);
    // 3333 pending, then BEEF on the boundary cycle
    chk_at(95,  "fb_cycle",      2'd3, 4'b0111, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(96,  "bypass_BEEF",   2'd0, 4'b1110, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1);
    chk_at(97,  "bypass_ack1",   2'd0, 4'b1110, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_at(100, "BEEF_d1",       2'd1, 4'b1101, 4'hE, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(108, "BEEF_d3",       2'd3, 4'b0111, 4'hB, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(112, "old_pend_drop", 2'd0, 4'b1110, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1);
    // leading-zero blanking with 0070
    chk_at(124, "lz_nonzero",    2'd3, 4'b0111, 4'hB, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(128, "commit_0070",   2'd0, 4'b1110, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk_at(132, "lz_d1_lit",     2'd1, 4'b1101, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(136, "lz_d2_blank",   2'd2, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_at(140, "lz_d3_blank",   2'd3, 4'b1111, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_at(141, "lz_off_now",    2'd3, 4'b0111, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(144, "lz_off_d0",     2'd0, 4'b1110, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk_at(148, "lz_off_d1",     2'd1, 4'b1101, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(152, "lz_off_d2",     2'd2, 4'b1011, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    ack_q.push_back(base + 32);
    ack_q.push_back(base + 64);
    ack_q.push_back(base + 96);
    ack_q.push_back(base + 128);

    go_to(21);  pulse_load(16'h12A4, 4'b0010);
    go_to(50);  pulse_load(16'h1111, 4'b0000);
    go_to(55);  pulse_load(16'h2222, 4'b0000);
    go_to(85);  pulse_load(16'h3333, 4'b1111);
    go_to(95);  pulse_load(16'hBEEF, 4'b0001);
    go_to(115); pulse_load(16'h0070, 4'b0000);
    go_to(120); blank_lz = 1'b1;
    go_to(141); blank_lz = 1'b0;
    go_to(150); pulse_load(16'h5555, 4'b1111);

    // reset with a request pending, mid-digit
    go_to(153);
    reset = 1'b0;
    step();
    reset = 1'b1;
    base  = cyc;

    chk_at(0,  "rst2_state",     2'd0, 4'b1110, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(2,  "rst2_pre_clr",   2'd0, 4'b1110, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(4,  "rst2_d1",        2'd1, 4'b1101, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(16, "rst2_frame1",    2'd0, 4'b1110, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk_at(17, "rst2_noack",     2'd0, 4'b1110, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(20, "rst2_f1_d1",     2'd1, 4'b1101, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk_at(32, "rst2_frame2",    2'd0, 4'b1110, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk_at(36, "rst2_f2_d1",     2'd1, 4'b1101, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);

    go_to(40);
    done = 1'b1;
    step();
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
